// File: rtl/setup_fields.sv
// -----------------------------------------------------------------------------
// setup_fields
//
// Password-protected configuration editor driven by a keypad digit buffer.
// A setup request enters AUTH; '*' after the master password enters EDIT,
// where each '*' stores the typed digits into the current field's shadow and
// steps to the next field, and '#' stores the last entry and commits the
// whole shadow to cfg_out.
//
// Optional feature (macro SETUP_TIMEOUT_EN): adds parameter TIMEOUT_CYCLES
// and an inactivity counter that aborts AUTH/EDIT without committing.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   setup_on      in   request to enter setup (honoured in IDLE only)
//   digitos_value in   keypad buffer, newest digit in [3:0], empty = 0xF,
//                      0xA = '*', 0xB = '#'
//   digitos_valid in   one-cycle strobe: new digit present in [3:0]
//   display_en    out  setup owns the display (AUTH or EDIT)
//   field_idx     out  index of the field under edit
//   bcd_value     out  shadow of the current field in EDIT, all 0xF otherwise
//   cfg_out       out  committed configuration, field 0 in the LS slice
//   cfg_ok        out  one-cycle commit pulse
//   err           out  one-cycle pulse on rejected password / field entry
//   setup_abort   out  one-cycle pulse on inactivity abort (0 without timeout)
// -----------------------------------------------------------------------------
module setup_fields #(
`ifdef SETUP_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 1000,
`endif
    parameter int unsigned N_FIELDS     = 4,
    parameter int unsigned FIELD_DIGITS = 2,
    parameter int unsigned PWD_DIGITS   = 4,
    parameter int unsigned MAX_DIGITS   = 20,
    parameter logic [4*PWD_DIGITS-1:0]            MASTER_INIT = 16'h1234,
    parameter logic [4*FIELD_DIGITS*N_FIELDS-1:0] CFG_INIT    = '0,
    localparam int unsigned FIW = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1,
    localparam int unsigned FW  = 4 * FIELD_DIGITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     setup_on,
    input  logic [4*MAX_DIGITS-1:0]  digitos_value,
    input  logic                     digitos_valid,
    output logic                     display_en,
    output logic [FIW-1:0]           field_idx,
    output logic [FW-1:0]            bcd_value,
    output logic [FW*N_FIELDS-1:0]   cfg_out,
    output logic                     cfg_ok,
    output logic                     err,
    output logic                     setup_abort
);

    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        AUTH,
        EDIT
    } state_t;

    state_t state_q, state_d;

    logic                         display_en_q,  display_en_d;
    logic [FIW-1:0]               field_idx_q,   field_idx_d;
    logic [FW-1:0]                bcd_value_q,   bcd_value_d;
    logic [N_FIELDS-1:0][FW-1:0]  cfg_q,         cfg_d;
    logic [N_FIELDS-1:0][FW-1:0]  shadow_q,      shadow_d;
    logic                         cfg_ok_q,      cfg_ok_d;
    logic                         err_q,         err_d;
    logic                         setup_abort_q, setup_abort_d;

    // Key decode: only terminators in nibble 0 trigger any action.
    logic key_star, key_hash;
    assign key_star = digitos_valid && (digitos_value[3:0] == 4'hA);
    assign key_hash = digitos_valid && (digitos_value[3:0] == 4'hB);

    // Password: the PWD_DIGITS nibbles just before the terminator must match,
    // and the nibble beyond them must be empty (no extra leading digits).
    logic pwd_ok;
    assign pwd_ok = (digitos_value[4*PWD_DIGITS+3:4] == MASTER_INIT) &&
                    (digitos_value[4*(PWD_DIGITS+1) +: 4] == 4'hF);

    // -------------------------------------------------------------------------
    // Field entry parse: digits from nibble 1 upward until the first 0xF.
    // -------------------------------------------------------------------------
    logic [CW-1:0] entry_cnt;
    logic          entry_stop;
    logic          entry_bad_digit;
    logic          entry_bad;
    logic [FW-1:0] entry_val;
    logic [3:0]    entry_nib;

    always_comb begin
        entry_cnt       = '0;
        entry_stop      = 1'b0;
        entry_bad_digit = 1'b0;
        entry_nib       = 4'hF;
        for (int unsigned i = 1; i < MAX_DIGITS; i++) begin
            entry_nib = digitos_value[4*i +: 4];
            if (!entry_stop) begin
                if (entry_nib == 4'hF) begin
                    entry_stop = 1'b1;
                end else begin
                    entry_cnt = entry_cnt + CW'(1);
                    if (entry_nib > 4'd9) begin
                        entry_bad_digit = 1'b1;
                    end
                end
            end
        end

        // Right-aligned: nibble 1 (newest) becomes the LS digit, unused
        // upper digits are zero.
        entry_val = '0;
        for (int unsigned j = 0; j < FIELD_DIGITS; j++) begin
            if (CW'(j) < entry_cnt) begin
                entry_val[4*j +: 4] = digitos_value[4*(j+1) +: 4];
            end
        end
    end

    assign entry_bad = entry_bad_digit || (entry_cnt > CW'(FIELD_DIGITS));

    // -------------------------------------------------------------------------
    // Inactivity timeout
    // -------------------------------------------------------------------------
    logic timeout_hit;

`ifdef SETUP_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;

    // Fires on the edge where the counter would reach TIMEOUT_CYCLES.
    assign timeout_hit = (state_q != IDLE) &&
                         (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        if ((state_q == IDLE) || (state_d != state_q) || digitos_valid) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State register (and registered outputs / shadow)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            display_en_q  <= 1'b0;
            field_idx_q   <= '0;
            bcd_value_q   <= '1;
            cfg_q         <= CFG_INIT;
            shadow_q      <= '0;
            cfg_ok_q      <= 1'b0;
            err_q         <= 1'b0;
            setup_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            display_en_q  <= display_en_d;
            field_idx_q   <= field_idx_d;
            bcd_value_q   <= bcd_value_d;
            cfg_q         <= cfg_d;
            shadow_q      <= shadow_d;
            cfg_ok_q      <= cfg_ok_d;
            err_q         <= err_d;
            setup_abort_q <= setup_abort_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (setup_on) begin
                    state_d = AUTH;
                end
            end
            AUTH: begin
                if (key_star) begin
                    state_d = pwd_ok ? EDIT : IDLE;
                end else if (key_hash) begin
                    state_d = IDLE;
                end
            end
            EDIT: begin
                if (key_hash) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any digit sampled on the same edge.
        if (timeout_hit) begin
            state_d = IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        field_idx_d   = field_idx_q;
        shadow_d      = shadow_q;
        cfg_d         = cfg_q;
        cfg_ok_d      = 1'b0;
        err_d         = 1'b0;
        setup_abort_d = 1'b0;

        if (timeout_hit) begin
            setup_abort_d = 1'b1;
            shadow_d      = '0;
            field_idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                AUTH: begin
                    if (key_star) begin
                        if (pwd_ok) begin
                            shadow_d    = cfg_q;
                            field_idx_d = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                EDIT: begin
                    if (key_star || key_hash) begin
                        if (entry_bad) begin
                            err_d = 1'b1;
                        end else if (entry_cnt != '0) begin
                            shadow_d[field_idx_q] = entry_val;
                        end
                    end
                    if (key_star && !entry_bad) begin
                        field_idx_d = (field_idx_q == FIW'(N_FIELDS - 1)) ?
                                      '0 : field_idx_q + FIW'(1);
                    end
                    // Commit uses the shadow including the final entry, and
                    // happens even when that entry was rejected.
                    if (key_hash) begin
                        cfg_d       = shadow_d;
                        cfg_ok_d    = 1'b1;
                        field_idx_d = '0;
                    end
                end
                default: ;
            endcase
        end

        display_en_d = (state_d != IDLE);
        bcd_value_d  = (state_d == EDIT) ? shadow_d[field_idx_d] : '1;
    end

    assign display_en  = display_en_q;
    assign field_idx   = field_idx_q;
    assign bcd_value   = bcd_value_q;
    assign cfg_out     = cfg_q;
    assign cfg_ok      = cfg_ok_q;
    assign err         = err_q;
    assign setup_abort = setup_abort_q;

endmodule

// File: tb/tb_setup_fields.sv
// -----------------------------------------------------------------------------
// tb_setup_fields
//
// Directed bench for setup_fields. A keypad buffer model builds digitos_value,
// a behavioural model pushes the expected registered outputs to a scoreboard
// queue as each cycle's stimulus is driven, and the entry is popped and
// compared after the clock edge. A second instance with N_FIELDS=3 checks the
// field index wrap.
// -----------------------------------------------------------------------------
module tb_setup_fields;

    localparam int NF = 4;
    localparam int FD = 2;
    localparam int MD = 20;
    localparam int FW = 8;

    logic              clk;
    logic              rst;
    logic              setup_on;
    logic              digitos_valid;
    logic [4*MD-1:0]   digitos_value;

    logic              display_en;
    logic [1:0]        field_idx;
    logic [FW-1:0]     bcd_value;
    logic [NF*FW-1:0]  cfg_out;
    logic              cfg_ok;
    logic              err;
    logic              setup_abort;

    logic              display_en3;
    logic [1:0]        field_idx3;
    logic [FW-1:0]     bcd_value3;
    logic [3*FW-1:0]   cfg_out3;
    logic              cfg_ok3;
    logic              err3;
    logic              setup_abort3;

    setup_fields #(
`ifdef SETUP_TIMEOUT_EN
        .TIMEOUT_CYCLES(50),
`endif
        .N_FIELDS(4),
        .FIELD_DIGITS(2),
        .PWD_DIGITS(4),
        .MAX_DIGITS(20),
        .MASTER_INIT(16'h1234)
    ) dut (
        .clk(clk), .rst(rst), .setup_on(setup_on),
        .digitos_value(digitos_value), .digitos_valid(digitos_valid),
        .display_en(display_en), .field_idx(field_idx), .bcd_value(bcd_value),
        .cfg_out(cfg_out), .cfg_ok(cfg_ok), .err(err), .setup_abort(setup_abort)
    );

    setup_fields #(
        .N_FIELDS(3)
    ) dut3 (
        .clk(clk), .rst(rst), .setup_on(setup_on),
        .digitos_value(digitos_value), .digitos_valid(digitos_valid),
        .display_en(display_en3), .field_idx(field_idx3), .bcd_value(bcd_value3),
        .cfg_out(cfg_out3), .cfg_ok(cfg_ok3), .err(err3), .setup_abort(setup_abort3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        de;
        logic [1:0]  idx;
        logic [7:0]  bcd;
        logic [31:0] cfg;
        logic        ok;
        logic        er;
        logic        ab;
    } obs_t;

    int    total = 0;
    int    bad   = 0;
    int    ok_pulses  = 0;
    int    err_pulses = 0;
    string cur_tag = "init";

    // Pulse counters, sampled mid-cycle.
    always @(posedge clk) begin
        #2;
        if (cfg_ok === 1'b1) ok_pulses++;
        if (err === 1'b1) err_pulses++;
    end

    // Model state
    int         m_state;   // 0 idle, 1 auth, 2 edit
    int         m_idx;
    logic [7:0] m_sh  [NF];
    logic [7:0] m_cfg [NF];
    logic [3:0] kb [$];    // keypad digits, oldest first
    obs_t       sbq [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", cur_tag, tag, obs, exp);
        end
    endtask

    function automatic obs_t model_outputs(input logic ok, input logic e);
        obs_t o;
        o.de  = (m_state != 0);
        o.idx = 2'(m_idx);
        o.bcd = (m_state == 2) ? m_sh[m_idx] : 8'hFF;
        o.cfg = {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]};
        o.ok  = ok;
        o.er  = e;
        o.ab  = 1'b0;
        return o;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_idx   = 0;
        for (int i = 0; i < NF; i++) begin
            m_sh[i]  = 8'h00;
            m_cfg[i] = 8'h00;
        end
    endtask

    task automatic model_step(input logic sv, input logic vv);
        logic       ok, e, badent;
        logic [3:0] k;
        logic [7:0] v;
        int         n;
        ok = 1'b0;
        e  = 1'b0;
        k  = (kb.size() > 0) ? kb[kb.size()-1] : 4'hF;
        if (m_state == 0) begin
            if (sv) m_state = 1;
        end else if (vv && (k == 4'hA || k == 4'hB)) begin
            n = kb.size() - 1;
            if (m_state == 1) begin
                if (k == 4'hA && n == 4 && kb[0] == 4'd1 && kb[1] == 4'd2 &&
                    kb[2] == 4'd3 && kb[3] == 4'd4) begin
                    m_state = 2;
                    m_idx   = 0;
                    for (int i = 0; i < NF; i++) m_sh[i] = m_cfg[i];
                end else begin
                    if (k == 4'hA) e = 1'b1;
                    m_state = 0;
                end
            end else begin
                badent = (n > FD);
                v = 8'h00;
                for (int i = 0; i < n; i++) begin
                    if (kb[i] > 4'd9) badent = 1'b1;
                    v = {v[3:0], kb[i]};
                end
                if (badent) e = 1'b1;
                else if (n > 0) m_sh[m_idx] = v;
                if (k == 4'hA) begin
                    if (!badent) m_idx = (m_idx + 1) % NF;
                end else begin
                    for (int i = 0; i < NF; i++) m_cfg[i] = m_sh[i];
                    ok      = 1'b1;
                    m_state = 0;
                    m_idx   = 0;
                end
            end
        end
        sbq.push_back(model_outputs(ok, e));
    endtask

    // One clock: drive at negedge, push expectation, compare after posedge.
    task automatic tick(input logic sv, input logic vv);
        obs_t o, e;
        setup_on      = sv;
        digitos_valid = vv;
        model_step(sv, vv);
        @(posedge clk);
        #1;
        o = {display_en, field_idx, bcd_value, cfg_out, cfg_ok, err, setup_abort};
        e = sbq.pop_front();
        check("outputs", 64'(o), 64'(e));
        @(negedge clk);
        setup_on      = 1'b0;
        digitos_valid = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        kb.push_back(k);
        digitos_value = '1;
        for (int i = 0; i < kb.size() && i < MD; i++)
            digitos_value[4*i +: 4] = kb[kb.size()-1-i];
        tick(1'b0, 1'b1);
        if (k == 4'hA || k == 4'hB) kb.delete();
        tick(1'b0, 1'b0);
    endtask

    task automatic enter_setup();
        kb.delete();
        digitos_value = '1;
        tick(1'b1, 1'b0);
    endtask

    task automatic password();
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'hA);
    endtask

    function automatic logic [63:0] reset_vec();
        return 64'({1'b0, 2'b00, 8'hFF, 32'h0, 1'b0, 1'b0, 1'b0});
    endfunction

    initial begin : stim
        int p_ok, p_err;
        int exp3 [5];
        exp3 = '{0, 1, 2, 0, 1};

        rst           = 1'b0;
        setup_on      = 1'b0;
        digitos_valid = 1'b0;
        digitos_value = '1;
        model_reset();
        #1 rst = 1'b1;
        @(negedge clk);

        cur_tag = "reset";
        check("outs", 64'({display_en, field_idx, bcd_value, cfg_out, cfg_ok, err, setup_abort}),
              reset_vec());
        rst = 1'b0;

        // Authenticate and commit immediately.
        cur_tag = "basic";
        p_ok = ok_pulses;
        enter_setup();
        password();
        key(4'hB);
        check("ok_count", 64'(ok_pulses - p_ok), 64'd1);
        check("cfg", 64'(cfg_out), 64'h0);
        check("display", 64'(display_en), 64'd0);

        // 1..8 bare '*' before '#': same result every time.
        for (int n = 1; n <= 8; n++) begin
            cur_tag = $sformatf("stars%0d", n);
            p_ok = ok_pulses;
            enter_setup();
            password();
            for (int s = 0; s < n; s++) key(4'hA);
            key(4'hB);
            check("ok_count", 64'(ok_pulses - p_ok), 64'd1);
            check("cfg", 64'(cfg_out), 64'h0);
        end

        // Two fields edited.
        cur_tag = "edit2";
        enter_setup();
        password();
        key(4'd4); key(4'd2); key(4'hA); key(4'd7); key(4'hB);
        check("cfg", 64'(cfg_out), 64'h0000_0742);

        // Wrong password.
        cur_tag = "badpwd";
        p_ok  = ok_pulses;
        p_err = err_pulses;
        enter_setup();
        key(4'd1); key(4'd2); key(4'd3); key(4'd5); key(4'hA);
        check("err_count", 64'(err_pulses - p_err), 64'd1);
        check("ok_count", 64'(ok_pulses - p_ok), 64'd0);
        check("display", 64'(display_en), 64'd0);

        // Rejected entries keep field_idx, setup_on ignored, idx wrap on N=3.
        cur_tag = "badentry";
        p_err = err_pulses;
        enter_setup();
        password();
        key(4'd1); key(4'd2); key(4'd3); key(4'hA);
        check("idx", 64'(field_idx), 64'd0);
        key(4'hC); key(4'hA);
        check("idx_hex", 64'(field_idx), 64'd0);
        check("err_count", 64'(err_pulses - p_err), 64'd2);
        tick(1'b1, 1'b0);

        cur_tag = "wrap3";
        check("idx3_0", 64'(field_idx3), 64'(exp3[0]));
        for (int s = 1; s < 5; s++) begin
            key(4'hA);
            check($sformatf("idx3_%0d", s), 64'(field_idx3), 64'(exp3[s]));
        end

        // '#' with an invalid entry still commits.
        cur_tag = "badcommit";
        p_ok  = ok_pulses;
        p_err = err_pulses;
        key(4'd1); key(4'd2); key(4'd3); key(4'hB);
        check("ok_count", 64'(ok_pulses - p_ok), 64'd1);
        check("err_count", 64'(err_pulses - p_err), 64'd1);
        check("cfg", 64'(cfg_out), 64'h0000_0742);

        // '#' in AUTH leaves quietly; terminators in IDLE do nothing.
        cur_tag = "authhash";
        p_err = err_pulses;
        enter_setup();
        key(4'hB);
        key(4'hA);
        check("err_count", 64'(err_pulses - p_err), 64'd0);

        // Reset while editing discards everything.
        cur_tag = "rst_edit";
        enter_setup();
        password();
        key(4'd9);
        rst = 1'b1;
        #1;
        check("outs_async", 64'({display_en, field_idx, bcd_value, cfg_out, cfg_ok, err, setup_abort}),
              reset_vec());
        @(negedge clk);
        check("outs_held", 64'({display_en, field_idx, bcd_value, cfg_out, cfg_ok, err, setup_abort}),
              reset_vec());
        rst = 1'b0;
        model_reset();
        kb.delete();

        cur_tag = "after_rst";
        enter_setup();
        password();
        key(4'd5); key(4'hB);
        check("cfg", 64'(cfg_out), 64'h0000_0005);

`ifdef SETUP_TIMEOUT_EN
        cur_tag = "timeout";
        enter_setup();
        password();
        // Entry edge and one idle edge are already behind us.
        for (int i = 2; i < 50; i++) begin
            @(posedge clk);
            #1;
            check("abort_low", 64'({setup_abort, display_en}), 64'b01);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        check("abort", 64'({setup_abort, display_en}), 64'b10);
        check("cfg", 64'(cfg_out), 64'h0000_0005);
        @(negedge clk);
        m_state = 0;
        m_idx   = 0;
        for (int i = 0; i < NF; i++) m_sh[i] = 8'h00;
        tick(1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
